cpu_mem_responder: RTL and testbench

Memory-side responder for the S-Machine CPU's instruction and data ports. It holds a single 256×16 word array. It returns the instruction at `PC` and the data word at `addr` one clock later, and commits CPU writes. It also includes a valid/ready program loader that fills the array before the CPU is released via `cpu_enable`. It sits beside the CPU top level and connects `inst`/`data_in_memory` back to the CPU.

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/cpu_mem_array.sv | 39 +++
 rtl/cpu_mem_responder.sv | 111 +++++++++++
 tb/tb_cpu_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the S-Machine CPU memory responder:
// controller states, default widths and the CPU write-select encoding.
package cpu_mem_pkg;

  localparam int unsigned CPU_ADDR_W = 8;
  localparam int unsigned CPU_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } mem_state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } wr_sel_t;

endpackage

// File: rtl/cpu_mem_array.sv
// Two-read, one-write synchronous word array with registered read ports.
// Reads sample the array before the same-edge write (read-before-write).
module cpu_mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (rd_en) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the S-Machine CPU with a valid/ready program loader.
// Optional write protection below PROG_LIMIT: define CPU_MEM_RESPONDER_WPROT_EN.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = CPU_ADDR_W,
  parameter int unsigned DATA_W     = CPU_DATA_W,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned PROG_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] load_count,
  output logic              cpu_enable,
  input  logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read_write_memory,
  input  logic [DATA_W-1:0] data_out_memory,
  output logic [DATA_W-1:0] data_in_memory,
  output logic              wp_fault
);

`ifdef CPU_MEM_RESPONDER_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  localparam logic [ADDR_W:0] PROG_LIMIT_W = (ADDR_W+1)'(PROG_LIMIT);

  mem_state_t        state;
  logic              load_fire;
  logic              cpu_wr;
  logic              wp_hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // start_load takes priority over a loader beat arriving in the same cycle.
  always_comb begin
    load_fire = (state == ST_LOAD) && load_valid && !start_load;
    cpu_wr    = (state == ST_RUN) && (read_write_memory == WR);
    wp_hit    = WPROT && cpu_wr && ({1'b0, addr} < PROG_LIMIT_W);
    mem_we    = load_fire || (cpu_wr && !wp_hit);
    mem_waddr = addr;
    mem_wdata = data_out_memory;
    if (state == ST_LOAD) begin
      mem_waddr = load_count;
      mem_wdata = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      load_count <= '0;
      load_ready <= 1'b0;
      cpu_enable <= 1'b0;
      wp_fault   <= 1'b0;
    end else if (start_load) begin
      state      <= ST_LOAD;
      load_count <= '0;
      load_ready <= 1'b1;
      cpu_enable <= 1'b0;
      wp_fault   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_valid) begin
            load_count <= load_count + ADDR_W'(1);
            if (load_last) begin
              state      <= ST_RUN;
              load_ready <= 1'b0;
              cpu_enable <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (wp_hit) begin
            wp_fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  cpu_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (state == ST_RUN),
    .raddr_a (PC),
    .raddr_b (addr),
    .rdata_a (inst),
    .rdata_b (data_in_memory),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder against an array-based reference model.
module tb_cpu_mem_responder;

`ifdef CPU_MEM_RESPONDER_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_load;
  logic        load_valid;
  logic        load_ready;
  logic        load_last;
  logic [15:0] load_data;
  logic [7:0]  load_count;
  logic        cpu_enable;
  logic [7:0]  PC;
  logic [15:0] inst;
  logic [7:0]  addr;
  logic        read_write_memory;
  logic [15:0] data_out_memory;
  logic [15:0] data_in_memory;
  logic        wp_fault;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model [256];
  logic        wp_exp;
  logic [15:0] exp_inst;
  logic [15:0] exp_data;
  logic [15:0] words [3];
  int          n;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_load        (start_load),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_last         (load_last),
    .load_data         (load_data),
    .load_count        (load_count),
    .cpu_enable        (cpu_enable),
    .PC                (PC),
    .inst              (inst),
    .addr              (addr),
    .read_write_memory (read_write_memory),
    .data_out_memory   (data_out_memory),
    .data_in_memory    (data_in_memory),
    .wp_fault          (wp_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst"}, 32'(inst), 32'h0);
    check({tag, "_data"}, 32'(data_in_memory), 32'h0);
    check({tag, "_count"}, 32'(load_count), 32'h0);
    check({tag, "_ready"}, 32'(load_ready), 32'h0);
    check({tag, "_enable"}, 32'(cpu_enable), 32'h0);
    check({tag, "_wpf"}, 32'(wp_fault), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; start_load = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; PC = '0; addr = '0; read_write_memory = 1'b0;
    data_out_memory = '0; wp_exp = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // IDLE: outputs hold while addresses move
    PC = 8'h05; addr = 8'h07;
    tick(); tick();
    check("idle_hold_inst", 32'(inst), 32'h0);
    check("idle_hold_data", 32'(data_in_memory), 32'h0);
    check("idle_ready", 32'(load_ready), 32'h0);

    // Three-word load
    start_load = 1'b1; tick(); start_load = 1'b0;
    check("load_ready_up", 32'(load_ready), 32'h1);
    check("load_count_start", 32'(load_count), 32'h0);
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = words[i]; load_last = (i == 2);
      tick();
      model[i] = words[i];
      check("load3_count", 32'(load_count), 32'(i + 1));
      check("load3_enable", 32'(cpu_enable), (i == 2) ? 32'h1 : 32'h0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("load3_ready_down", 32'(load_ready), 32'h0);

    PC = 8'd1; addr = 8'd0; tick();
    check("fetch_pc1", 32'(inst), 32'h2222);
    check("read_a0", 32'(data_in_memory), 32'h1111);
    PC = 8'd2; tick();
    check("fetch_pc2", 32'(inst), 32'h3333);

    // Full reload with wrap; CPU write attempts must be ignored while loading
    start_load = 1'b1; tick(); start_load = 1'b0;
    check("reload_enable_drop", 32'(cpu_enable), 32'h0);
    check("reload_count_clear", 32'(load_count), 32'h0);
    read_write_memory = 1'b1; addr = 8'hFF; data_out_memory = 16'hDEAD;
    n = 0;
    for (int cyc = 0; cyc < 3000 && n < 258; cyc++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = 16'($urandom);
      load_last  = load_valid && (n == 257);
      tick();
      if (load_valid) begin
        model[n % 256] = load_data;
        n++;
        if (n == 256) check("load_count_wrap", 32'(load_count), 32'h0);
      end
      if (n < 258) check("load_inst_hold", 32'(inst), 32'h3333);
    end
    load_valid = 1'b0; load_last = 1'b0; read_write_memory = 1'b0;
    check("full_load_done", 32'(n), 32'd258);
    check("full_load_count", 32'(load_count), 32'h2);
    check("full_load_enable", 32'(cpu_enable), 32'h1);

    // Write then read back at 0x80
    PC = 8'h00; addr = 8'h80; read_write_memory = 1'b1; data_out_memory = 16'hBEEF;
    exp_data = model[8'h80];
    tick();
    model[8'h80] = 16'hBEEF;
    check("wr80_old", 32'(data_in_memory), 32'(exp_data));
    read_write_memory = 1'b0; tick();
    check("wr80_new", 32'(data_in_memory), 32'hBEEF);

    // Fetch and write to the same address in one cycle
    PC = 8'h80; read_write_memory = 1'b1; data_out_memory = 16'hCAFE;
    tick();
    model[8'h80] = 16'hCAFE;
    check("same_cycle_inst_old", 32'(inst), 32'hBEEF);
    check("same_cycle_data_old", 32'(data_in_memory), 32'hBEEF);
    read_write_memory = 1'b0; tick();
    check("same_cycle_inst_new", 32'(inst), 32'hCAFE);

    // Write into the program region
    addr = 8'h10; read_write_memory = 1'b1; data_out_memory = 16'hDEAD;
    exp_data = model[8'h10];
    tick();
    if (WPROT) wp_exp = 1'b1;
    else model[8'h10] = 16'hDEAD;
    check("wp_old", 32'(data_in_memory), 32'(exp_data));
    check("wp_fault_set", 32'(wp_fault), 32'(wp_exp));
    read_write_memory = 1'b0; tick();
    check("wp_readback", 32'(data_in_memory), 32'(model[8'h10]));

    // Random RUN traffic
    for (int i = 0; i < 300; i++) begin
      PC = 8'($urandom); addr = 8'($urandom);
      read_write_memory = ($urandom_range(0, 2) == 0);
      data_out_memory = 16'($urandom);
      exp_inst = model[PC]; exp_data = model[addr];
      tick();
      if (read_write_memory) begin
        if (WPROT && addr < 8'd64) wp_exp = 1'b1;
        else model[addr] = data_out_memory;
      end
      check("rand_inst", 32'(inst), 32'(exp_inst));
      check("rand_data", 32'(data_in_memory), 32'(exp_data));
      check("rand_wpf", 32'(wp_fault), 32'(wp_exp));
    end
    read_write_memory = 1'b0;

    // start_load clears the fault; partial load then reset
    PC = 8'h22; exp_inst = model[8'h22];
    start_load = 1'b1; tick(); start_load = 1'b0;
    wp_exp = 1'b0;
    check("sl_wpf_clear", 32'(wp_fault), 32'h0);
    check("sl_enable", 32'(cpu_enable), 32'h0);
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = (i == 0) ? 16'hAAAA : 16'hBBBB;
      tick();
    end
    load_valid = 1'b0;
    check("partial_count", 32'(load_count), 32'h2);
    check("partial_inst_hold", 32'(inst), 32'(exp_inst));
    rst_n = 1'b0; #1;
    check_reset_outputs("midload_reset");
    tick(); rst_n = 1'b1;

    // IDLE write is discarded; partial image survives
    PC = 8'h03; addr = 8'h01; read_write_memory = 1'b1; data_out_memory = 16'h5555;
    tick(); tick();
    read_write_memory = 1'b0;
    check("idle2_inst", 32'(inst), 32'h0);
    check("idle2_ready", 32'(load_ready), 32'h0);
    start_load = 1'b1; tick(); start_load = 1'b0;
    load_valid = 1'b1; load_last = 1'b1; load_data = 16'h7777;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    check("final_enable", 32'(cpu_enable), 32'h1);
    check("final_count", 32'(load_count), 32'h1);
    PC = 8'h00; addr = 8'h01; tick();
    check("final_inst_a0", 32'(inst), 32'h7777);
    check("final_retained_a1", 32'(data_in_memory), 32'hBBBB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
